// File: rtl/evr_trigger_sequencer.sv
// evr_trigger_sequencer: bank of NCH event-triggered pulse generators fed by one
// EVR event-code stream. Each channel holds a shadow configuration that is copied
// into its active registers only while the channel is idle. Once an event matches,
// the channel waits a programmed delay and then emits a pulse of programmed width.
//
// Config interface: cfg_wr and cfg_commit are single-cycle strobes that are accepted
// on every cycle, so there is no ready signal. A commit to a busy channel is held
// pending. cfg_busy stays high while any commit is still waiting for its channel
// to return to IDLE.
module evr_trigger_sequencer #(
    parameter  int NCH = 4,
    parameter  int CW  = 32,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       eventStream,
    input  logic             cfg_wr,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [1:0]       cfg_sel,
    input  logic [31:0]      cfg_data,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    output logic [NCH-1:0]   trigger,
    output logic [NCH-1:0]   active,
    output logic [NCH-1:0]   missed,
    output logic [2*NCH-1:0] stateDebug
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } chState_t;

    logic [NCH-1:0] pendingVec;

    assign cfg_busy = |pendingVec;

    for (genvar ch = 0; ch < NCH; ch++) begin : gChan
        logic [7:0]    shEvent, acEvent;
        logic [CW-1:0] shDelay, shWidth, acDelay, acWidth;
        logic          shEnable, shPol, acEnable, acPol;
        chState_t      state, stateNext;
        logic [CW-1:0] cnt, cntNext;
        logic          pending, pendingNext;
        logic          selected, match, copyNow;
        logic          trigNext, missedNext;
        logic          trigReg, missedReg;

        assign selected = (cfg_ch == CHW'(ch));

        // Match only ever looks at the active registers; a null code never fires.
        assign match = acEnable && (acEvent != 8'h00) && (eventStream == acEvent)
                       && (acWidth != '0);

        assign trigger[ch]            = trigReg;
        assign missed[ch]             = missedReg;
        assign active[ch]             = (state != IDLE);
        assign pendingVec[ch]         = pending;
        assign stateDebug[2*ch +: 2]  = state;

        // Shadow register writes, accepted in any channel state.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                shEvent  <= '0;
                shDelay  <= '0;
                shWidth  <= '0;
                shEnable <= 1'b0;
                shPol    <= 1'b0;
            end else if (cfg_wr && selected) begin
                case (cfg_sel)
                    2'd0: shEvent <= cfg_data[7:0];
                    2'd1: shDelay <= cfg_data[CW-1:0];
                    2'd2: shWidth <= cfg_data[CW-1:0];
                    default: begin
                        shPol    <= cfg_data[1];
                        shEnable <= cfg_data[0];
                    end
                endcase
            end
        end

        // Active config and pending flag: the copy lands only on an edge where the channel is IDLE.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                acEvent  <= '0;
                acDelay  <= '0;
                acWidth  <= '0;
                acEnable <= 1'b0;
                acPol    <= 1'b0;
                pending  <= 1'b0;
            end else begin
                pending <= pendingNext;
                if (copyNow) begin
                    acEvent  <= shEvent;
                    acDelay  <= shDelay;
                    acWidth  <= shWidth;
                    acEnable <= shEnable;
                    acPol    <= shPol;
                end
            end
        end

        // State register plus registered trigger/missed outputs.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                state     <= IDLE;
                cnt       <= '0;
                trigReg   <= 1'b0;
                missedReg <= 1'b0;
            end else begin
                state     <= stateNext;
                cnt       <= cntNext;
                trigReg   <= trigNext;
                missedReg <= missedNext;
            end
        end

        // Next-state logic: delay countdown, then pulse countdown, back to idle.
        always_comb begin
            stateNext = state;
            cntNext   = cnt;
            case (state)
                IDLE: begin
                    if (match) begin
                        if (acDelay == '0) begin
                            stateNext = PULSE;
                            cntNext   = acWidth - CW'(1);
                        end else begin
                            stateNext = DELAY;
                            cntNext   = acDelay - CW'(1);
                        end
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        stateNext = PULSE;
                        cntNext   = acWidth - CW'(1);
                    end else begin
                        cntNext = cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        stateNext = IDLE;
                    end else begin
                        cntNext = cnt - CW'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end

        // Output logic: commit handling, missed-event flag and the next trigger level.
        always_comb begin
            copyNow     = (state == IDLE) && (pending || (cfg_commit && selected));
            pendingNext = pending;
            if (copyNow) begin
                pendingNext = 1'b0;
            end else if (cfg_commit && selected) begin
                pendingNext = 1'b1;
            end
            missedNext = match && (state != IDLE);
            // Polarity must follow a commit landing this edge so the idle level tracks it.
            trigNext   = (copyNow ? shPol : acPol) ^ (stateNext == PULSE);
        end
    end

endmodule
